pll_lock_supervisor: RTL and testbench

//  Supervises the PLLA clock generator from the 50 MHz board clock domain.

---
 rtl/pll_lock_supervisor.sv | 198 +++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a stable lock, then releases the
// system reset. Retries on lock timeout, latches FAIL, and counts loss-of-lock events.
module pll_lock_supervisor #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned STABLE_CYCLES  = 5000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned LOSS_CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_lock_i,
  input  logic                  restart_i,
  output logic                  pll_reset_o,
  output logic                  sys_rst_o,
  output logic                  locked_o,
  output logic                  fail_o,
  output logic [7:0]            retry_cnt_o,
  output logic [LOSS_CNT_W-1:0] loss_cnt_o
);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam logic [31:0]           C_RST_LAST     = 32'(PLL_RST_CYCLES - 1);
  localparam logic [31:0]           C_TIMEOUT_LAST = 32'(LOCK_TIMEOUT - 1);
  localparam logic [31:0]           C_STABLE_DONE  = 32'(STABLE_CYCLES);
  localparam logic [7:0]            C_MAX_RETRIES  = 8'(MAX_RETRIES);
  localparam logic [LOSS_CNT_W-1:0] C_LOSS_MAX     = {LOSS_CNT_W{1'b1}};
  localparam logic [LOSS_CNT_W-1:0] C_LOSS_ONE     = LOSS_CNT_W'(1);

  state_t                r_state;
  logic [31:0]           r_timer;
  logic [7:0]            r_retry_cnt;
  logic [LOSS_CNT_W-1:0] r_loss_cnt;
  logic                  r_sync_meta;
  logic                  r_lock_s;
  logic                  r_pll_reset;
  logic                  r_sys_rst;
  logic                  r_locked;
  logic                  r_fail;

  state_t                w_state_nxt;
  logic [31:0]           w_timer_nxt;
  logic [7:0]            w_retry_nxt;
  logic [LOSS_CNT_W-1:0] w_loss_nxt;
  logic [7:0]            w_retry_inc;
  logic                  w_pll_reset_nxt;
  logic                  w_sys_rst_nxt;
  logic                  w_locked_nxt;
  logic                  w_fail_nxt;

  assign w_retry_inc = r_retry_cnt + 8'd1;

  // State register, synchronizer, counters and registered Moore outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_PLL_RST;
      r_timer     <= 32'd0;
      r_retry_cnt <= 8'd0;
      r_loss_cnt  <= '0;
      r_sync_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_pll_reset <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_locked    <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_sync_meta <= pll_lock_i;
      r_lock_s    <= r_sync_meta;
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_retry_cnt <= w_retry_nxt;
      r_loss_cnt  <= w_loss_nxt;
      r_pll_reset <= w_pll_reset_nxt;
      r_sys_rst   <= w_sys_rst_nxt;
      r_locked    <= w_locked_nxt;
      r_fail      <= w_fail_nxt;
    end
  end

  // Next-state, retry and loss-counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry_cnt;
    w_loss_nxt  = r_loss_cnt;
    if (restart_i) begin
      w_state_nxt = ST_PLL_RST;
      w_retry_nxt = 8'd0;
    end else begin
      case (r_state)
        ST_PLL_RST: begin
          if (r_timer == C_RST_LAST) begin
            w_state_nxt = ST_WAIT_LOCK;
          end else begin
            w_state_nxt = ST_PLL_RST;
          end
        end
        ST_WAIT_LOCK: begin
          // A lock seen on the expiry cycle wins over the timeout
          if (r_lock_s) begin
            w_state_nxt = ST_STABLE;
          end else if (r_timer == C_TIMEOUT_LAST) begin
            w_retry_nxt = w_retry_inc;
            if (w_retry_inc == C_MAX_RETRIES) begin
              w_state_nxt = ST_FAIL;
            end else begin
              w_state_nxt = ST_PLL_RST;
            end
          end else begin
            w_state_nxt = ST_WAIT_LOCK;
          end
        end
        ST_STABLE: begin
          // Timer counts the lock_s samples taken after the entry cycle
          if (!r_lock_s) begin
            w_state_nxt = ST_WAIT_LOCK;
          end else if (r_timer == C_STABLE_DONE) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_STABLE;
          end
        end
        ST_RUN: begin
          if (!r_lock_s) begin
            w_state_nxt = ST_PLL_RST;
            w_retry_nxt = 8'd0;
            if (r_loss_cnt == C_LOSS_MAX) begin
              w_loss_nxt = r_loss_cnt;
            end else begin
              w_loss_nxt = r_loss_cnt + C_LOSS_ONE;
            end
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_FAIL: begin
          w_state_nxt = ST_FAIL;
        end
        default: begin
          w_state_nxt = ST_PLL_RST;
        end
      endcase
    end
  end

  // Timer restarts on every state entry, including a restart into PLL_RST
  always_comb begin
    if (restart_i || (w_state_nxt != r_state)) begin
      w_timer_nxt = 32'd0;
    end else begin
      w_timer_nxt = r_timer + 32'd1;
    end
  end

  // Output decode from the next state so outputs align with the state register
  always_comb begin
    w_pll_reset_nxt = 1'b0;
    w_sys_rst_nxt   = 1'b1;
    w_locked_nxt    = 1'b0;
    w_fail_nxt      = 1'b0;
    case (w_state_nxt)
      ST_PLL_RST: begin
        w_pll_reset_nxt = 1'b1;
      end
      ST_WAIT_LOCK: begin
        w_pll_reset_nxt = 1'b0;
      end
      ST_STABLE: begin
        w_pll_reset_nxt = 1'b0;
      end
      ST_RUN: begin
        w_sys_rst_nxt = 1'b0;
        w_locked_nxt  = 1'b1;
      end
      ST_FAIL: begin
        w_pll_reset_nxt = 1'b1;
        w_fail_nxt      = 1'b1;
      end
      default: begin
        w_pll_reset_nxt = 1'b1;
      end
    endcase
  end

  assign pll_reset_o = r_pll_reset;
  assign sys_rst_o   = r_sys_rst;
  assign locked_o    = r_locked;
  assign fail_o      = r_fail;
  assign retry_cnt_o = r_retry_cnt;
  assign loss_cnt_o  = r_loss_cnt;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench: the stimulus side queues every expected output change with its cycle
// stamp; the monitor pops one entry each time the DUT output vector changes.
module tb_pll_lock_supervisor;

  logic       clk;
  logic       rst;
  logic       pll_lock_i;
  logic       restart_i;
  logic       pll_reset_o;
  logic       sys_rst_o;
  logic       locked_o;
  logic       fail_o;
  logic [7:0] retry_cnt_o;
  logic [7:0] loss_cnt_o;

  typedef struct {
    int          stamp;
    logic [19:0] val;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          cyc;
  int          n_vec;
  int          n_fail;
  logic        mon_en;
  logic        mon_started;
  logic [19:0] prev;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .LOSS_CNT_W    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_lock_i (pll_lock_i),
    .restart_i  (restart_i),
    .pll_reset_o(pll_reset_o),
    .sys_rst_o  (sys_rst_o),
    .locked_o   (locked_o),
    .fail_o     (fail_o),
    .retry_cnt_o(retry_cnt_o),
    .loss_cnt_o (loss_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int st, input logic pr, input logic sr, input logic lk,
                      input logic fl, input logic [7:0] rc, input logic [7:0] lc,
                      input string nm);
    exp_t e;
    e.stamp = st;
    e.val   = {pr, sr, lk, fl, rc, lc};
    e.name  = nm;
    q.push_back(e);
  endtask

  // Advance to 2 time units after the posedge that makes cyc == st
  task automatic at(input int st);
    while (cyc < st) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: any change of the output vector is a presented response
  always @(negedge clk) begin
    logic [19:0] cur;
    exp_t        e;
    if (mon_en) begin
      cur = {pll_reset_o, sys_rst_o, locked_o, fail_o, retry_cnt_o, loss_cnt_o};
      if (!mon_started || cur !== prev) begin
        n_vec = n_vec + 1;
        if (q.size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL unexpected_change: got %h at cycle %0d, required no change", cur, cyc);
        end else begin
          e = q.pop_front();
          if (cur !== e.val || cyc != e.stamp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d",
                     e.name, cur, cyc, e.val, e.stamp);
          end
        end
      end
      prev        = cur;
      mon_started = 1'b1;
    end
  end

  initial begin
    int d;
    int l;
    n_vec       = 0;
    n_fail      = 0;
    mon_en      = 1'b0;
    mon_started = 1'b0;
    prev        = 20'd0;
    rst         = 1'b1;
    pll_lock_i  = 1'b1;
    restart_i   = 1'b0;

    // Expected output changes, in time order (tuple: pll_reset sys_rst locked fail retry loss)
    push(2,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, "reset_values");
    push(7,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, "start_wait_lock");
    push(17, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, "start_run_14");
    for (int i = 0; i < 260; i++) begin
      d = 20 + 20 * i;
      l = (i + 1 > 255) ? 255 : i + 1;
      push(d + 3,  1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'(l), "loss_sysrst_3clk");
      push(d + 7,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'(l), "loss_pllrst_4cyc");
      push(d + 17, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'(l), "loss_relock_run");
    end
    push(5241, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd255, "restart_from_run");
    push(5245, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd255, "glitch_wait_lock");
    push(5261, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd255, "glitch_run_late");
    push(5271, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd255, "restart2");
    push(5275, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd255, "restart2_wait");
    push(5279, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0,   "rst_in_stable");
    push(5285, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0,   "rerun_wait");
    push(5295, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0,   "rerun_run");
    push(5303, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1,   "fail_loss");
    push(5307, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1,   "fail_wait1");
    push(5327, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1,   "timeout1_retry");
    push(5331, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1,   "fail_wait2");
    push(5351, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 8'd1,   "timeout2_fail");
    push(5381, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1,   "restart_from_fail");
    push(5385, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1,   "restart_fail_wait");
    push(5395, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd1,   "restart_fail_run");
    push(5399, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd2,   "tie_loss");
    push(5403, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd2,   "tie_wait");
    push(5432, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd2,   "tie_lock_wins");

    at(2);
    mon_en = 1'b1;
    at(3);
    rst = 1'b0;

    for (int i = 0; i < 260; i++) begin
      d = 20 + 20 * i;
      at(d);
      pll_lock_i = 1'b0;
      at(d + 1);
      pll_lock_i = 1'b1;
    end

    at(5240); restart_i = 1'b1;
    at(5241); restart_i = 1'b0;
    at(5248); pll_lock_i = 1'b0;
    at(5249); pll_lock_i = 1'b1;
    at(5270); restart_i = 1'b1;
    at(5271); restart_i = 1'b0;
    at(5278); rst = 1'b1;
    at(5281); rst = 1'b0;
    at(5300); pll_lock_i = 1'b0;
    at(5360); pll_lock_i = 1'b1;
    at(5380); restart_i = 1'b1;
    at(5381); restart_i = 1'b0;
    at(5396); pll_lock_i = 1'b0;
    at(5420); pll_lock_i = 1'b1;
    at(5450);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec  = n_vec + 1;
      n_fail = n_fail + 1;
      $display("FAIL %s: got no change, required %h at cycle %0d", e.name, e.val, e.stamp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
